// File: rtl/xga_timing_pkg.sv
// ---------------------------------------------------------------------------
// xga_timing_pkg
//   Shared raster constants for the 1024x768@60 (XGA) background pipeline.
//   The video timing generator and the downstream background stages import
//   this package, so they all agree on counter widths and porch/sync
//   geometry.
//   Contents: PIX_W and FRAME_CNT_W widths, the XGA horizontal/vertical
//   geometry and the sync polarity, MAX_TOTAL (the largest line or frame
//   length an 11-bit counter can hold), and sync_level(), which maps a
//   sync-window hit to the pad level.
// ---------------------------------------------------------------------------
package xga_timing_pkg;

  localparam int PIX_W       = 11;
  localparam int FRAME_CNT_W = 10;
  localparam int MAX_TOTAL   = 1 << PIX_W;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // XGA uses negative-going sync pulses.
  localparam logic XGA_SYNC_POL = 1'b0;

  // Pad level for a sync output: pol while inside the window, !pol outside.
  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : !pol;
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// ---------------------------------------------------------------------------
// timing_axis_counter
//   One raster axis, either horizontal or vertical. It is a wrap counter
//   that steps when en=1 and returns to 0 after TOTAL-1. It also decodes
//   three things from its own count: the terminal count, the active region
//   and the sync window.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous reset, active-high; count clears to 0
//   en        in   advance enable
//   cnt       out  current position, 0..TOTAL-1
//   tc        out  1 when cnt == TOTAL-1 (next enabled step wraps)
//   active    out  1 when cnt < ACTIVE
//   sync_win  out  1 when SYNC_START <= cnt < SYNC_END
// ---------------------------------------------------------------------------
module timing_axis_counter #(
  parameter int W          = 11,
  parameter int TOTAL      = 1344,
  parameter int ACTIVE     = 1024,
  parameter int SYNC_START = 1048,
  parameter int SYNC_END   = 1184
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         active,
  output logic         sync_win
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYN_BEG = W'(SYNC_START);
  localparam logic [W-1:0] SYN_END = W'(SYNC_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

  assign tc       = (cnt == LAST);
  assign active   = (cnt < ACT_END);
  assign sync_win = (cnt >= SYN_BEG) && (cnt < SYN_END);

endmodule

// File: rtl/xga_video_timing.sv
// ---------------------------------------------------------------------------
// xga_video_timing
//   Raster timing generator for the XGA background pipeline. It drives the
//   pixel position and active flag into the background stages, and it
//   drives hsync/vsync to the pad. It also gives downstream scroll logic a
//   frame_start strobe and a running frame count, so that logic can stay
//   synchronous on clk.
//   Every output is a registered decode of the internal (h,v) counters. The
//   decode loads on the same pix_ce edge that advances the counters, so the
//   outputs trail the counters by one enabled clock and stay aligned with
//   each other.
// Ports:
//   clk          in   pixel-domain clock
//   rst          in   asynchronous reset, active-high
//   pix_ce       in   pixel clock enable; state advances only when 1
//   pix_x        out  horizontal position, 0..H_TOTAL-1
//   pix_y        out  vertical position, 0..V_TOTAL-1
//   video_active out  pix_x < H_ACTIVE and pix_y < V_ACTIVE
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   line_start   out  one-clk pulse while pix_x == 0
//   frame_start  out  one-clk pulse while pix_x == 0 and pix_y == 0
//   frame_cnt    out  frames started since reset, wraps modulo 2^10
// ---------------------------------------------------------------------------
module xga_video_timing
  import xga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic SYNC_POL = XGA_SYNC_POL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_ce,
  output logic [PIX_W-1:0]       pix_x,
  output logic [PIX_W-1:0]       pix_y,
  output logic                   video_active,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are PIX_W bits wide, so reject any geometry they cannot hold.
  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
    $error("xga_video_timing: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
    $error("xga_video_timing: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end

  logic [PIX_W-1:0] h_cnt;
  logic [PIX_W-1:0] v_cnt;
  logic             h_tc;
  logic             h_act;
  logic             h_win;
  logic             v_act;
  logic             v_win;
  logic             v_tc_unused;
  logic             at_line_start;
  logic             at_frame_start;

  timing_axis_counter #(
    .W          (PIX_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (pix_ce),
    .cnt      (h_cnt),
    .tc       (h_tc),
    .active   (h_act),
    .sync_win (h_win)
  );

  // The vertical axis steps once per line, on the enabled edge where h wraps.
  timing_axis_counter #(
    .W          (PIX_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (pix_ce & h_tc),
    .cnt      (v_cnt),
    .tc       (v_tc_unused),
    .active   (v_act),
    .sync_win (v_win)
  );

  assign at_line_start  = (h_cnt == '0);
  assign at_frame_start = at_line_start && (v_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x        <= '0;
      pix_y        <= '0;
      video_active <= 1'b0;
      hsync        <= !SYNC_POL;
      vsync        <= !SYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
    end else if (pix_ce) begin
      pix_x        <= h_cnt;
      pix_y        <= v_cnt;
      video_active <= h_act & v_act;
      hsync        <= sync_level(h_win, SYNC_POL);
      vsync        <= sync_level(v_win, SYNC_POL);
      line_start   <= at_line_start;
      frame_start  <= at_frame_start;
      if (at_frame_start) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end else begin
      // The strobes last one clk, even when pix_ce stalls the raster.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xga_video_timing.sv
module tb_xga_video_timing;
  import xga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Full XGA instance for reset and line-level behaviour.
  logic                   x_rst, x_ce;
  logic [PIX_W-1:0]       x_pix_x, x_pix_y;
  logic                   x_video_active, x_hsync, x_vsync, x_line_start, x_frame_start;
  logic [FRAME_CNT_W-1:0] x_frame_cnt;
  logic [36:0]            x_obs;

  // Small geometry instance (8 x 7 raster, 56 clks/frame) for frame-level
  // behaviour, mid-frame reset and frame_cnt wrap within a short run.
  logic                   s_rst, s_ce;
  logic [PIX_W-1:0]       s_pix_x, s_pix_y;
  logic                   s_video_active, s_hsync, s_vsync, s_line_start, s_frame_start;
  logic [FRAME_CNT_W-1:0] s_frame_cnt;
  logic [36:0]            s_obs;

  assign x_obs = {x_pix_x, x_pix_y, x_video_active, x_hsync, x_vsync,
                  x_line_start, x_frame_start, x_frame_cnt};
  assign s_obs = {s_pix_x, s_pix_y, s_video_active, s_hsync, s_vsync,
                  s_line_start, s_frame_start, s_frame_cnt};

  localparam logic [36:0] RESET_VEC = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
  localparam logic [36:0] FIRST_VEC = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1};

  xga_video_timing u_dut_xga (
    .clk          (clk),
    .rst          (x_rst),
    .pix_ce       (x_ce),
    .pix_x        (x_pix_x),
    .pix_y        (x_pix_y),
    .video_active (x_video_active),
    .hsync        (x_hsync),
    .vsync        (x_vsync),
    .line_start   (x_line_start),
    .frame_start  (x_frame_start),
    .frame_cnt    (x_frame_cnt)
  );

  xga_video_timing #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b0)
  ) u_dut_small (
    .clk          (clk),
    .rst          (s_rst),
    .pix_ce       (s_ce),
    .pix_x        (s_pix_x),
    .pix_y        (s_pix_y),
    .video_active (s_video_active),
    .hsync        (s_hsync),
    .vsync        (s_vsync),
    .line_start   (s_line_start),
    .frame_start  (s_frame_start),
    .frame_cnt    (s_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    x_ce = 1'b1;
    repeat (3) tick();
    checks++;
    if (x_obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", x_obs, RESET_VEC);
    end
    x_rst = 1'b0;
    tick();
    checks++;
    if (x_obs !== FIRST_VEC) begin
      errors++;
      $display("FAIL first_edge: got %h expected %h", x_obs, FIRST_VEC);
    end
  endtask

  task automatic test_line_timing();
    int hs_len = 0;
    int hs_first = -1;
    int va_fall = -1;
    int last_ls = -1;
    int prev_ls = -1;
    for (int c = 1; c <= 2700; c++) begin
      int ex, ey;
      logic [36:0] exp_v;
      tick();
      ex = c % 1344;
      ey = c / 1344;
      exp_v = {11'(ex), 11'(ey), (ex < 1024), !(ex >= 1048 && ex < 1184), 1'b1,
               (ex == 0), 1'b0, 10'd1};
      checks++;
      if (x_obs !== exp_v) begin
        errors++;
        if (errors < 10) $display("FAIL line_vec c=%0d: got %h expected %h", c, x_obs, exp_v);
      end
      if (c < 1344 && x_hsync == 1'b0) begin
        hs_len++;
        if (hs_first < 0) hs_first = int'(x_pix_x);
      end
      if (va_fall < 0 && x_video_active == 1'b0) va_fall = int'(x_pix_x);
      if (x_line_start) begin
        prev_ls = last_ls;
        last_ls = c;
      end
    end
    checks++;
    if (hs_len != 136) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 136", hs_len);
    end
    checks++;
    if (hs_first != 1048) begin
      errors++;
      $display("FAIL hsync_start: got %0d expected 1048", hs_first);
    end
    checks++;
    if (va_fall != 1024) begin
      errors++;
      $display("FAIL active_fall: got %0d expected 1024", va_fall);
    end
    checks++;
    if (last_ls != 2688 || (last_ls - prev_ls) != 1344) begin
      errors++;
      $display("FAIL line_period: got last=%0d prev=%0d expected 2688/1344", last_ls, prev_ls);
    end
  endtask

  task automatic test_ce_stall();
    int n = 0;
    while (x_pix_x != 11'd1343 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL stall_seek: got timeout expected pix_x 1343");
    end
    tick();
    checks++;
    if (x_pix_x !== 11'd0 || x_pix_y !== 11'd3 || x_line_start !== 1'b1) begin
      errors++;
      $display("FAIL stall_ce1: got x=%0d y=%0d ls=%0d expected 0/3/1", x_pix_x, x_pix_y, x_line_start);
    end
    x_ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (x_pix_x !== 11'd0 || x_pix_y !== 11'd3 || x_line_start !== 1'b0 ||
          x_video_active !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got x=%0d y=%0d ls=%0d va=%0d expected 0/3/0/1",
                 k, x_pix_x, x_pix_y, x_line_start, x_video_active);
      end
    end
    x_ce = 1'b1;
    tick();
    checks++;
    if (x_pix_x !== 11'd1 || x_line_start !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: got x=%0d ls=%0d expected 1/0", x_pix_x, x_line_start);
    end
  endtask

  task automatic test_frame_timing();
    int vs_len = 0;
    int fs_seen = 0;
    int wraps = 0;
    int prev_y = -1;
    s_ce  = 1'b1;
    s_rst = 1'b0;
    for (int c = 0; c <= 121; c++) begin
      int ex, ey, fc;
      logic [36:0] exp_v;
      tick();
      ex = c % 8;
      ey = (c / 8) % 7;
      fc = c / 56 + 1;
      exp_v = {11'(ex), 11'(ey), (ex < 4 && ey < 3), !(ex >= 5 && ex < 7),
               !(ey >= 4 && ey < 6), (ex == 0), (ex == 0 && ey == 0), 10'(fc)};
      checks++;
      if (s_obs !== exp_v) begin
        errors++;
        if (errors < 10) $display("FAIL frame_vec c=%0d: got %h expected %h", c, s_obs, exp_v);
      end
      if (c < 56 && s_vsync == 1'b0) vs_len++;
      if (s_frame_start) begin
        if (c != fs_seen * 56) begin
          errors++;
          $display("FAIL frame_period: got fs at %0d expected %0d", c, fs_seen * 56);
        end
        fs_seen++;
      end
      if (prev_y == 6 && s_pix_y == 11'd0) wraps++;
      prev_y = int'(s_pix_y);
    end
    checks++;
    if (vs_len != 16) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected 16", vs_len);
    end
    checks++;
    if (fs_seen != 3) begin
      errors++;
      $display("FAIL frame_starts: got %0d expected 3", fs_seen);
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("FAIL y_wrap: got %0d expected 2", wraps);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(s_pix_y == 11'd2 && s_pix_x == 11'd3) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL mid_seek: got timeout expected (3,2)");
    end
    #2 s_rst = 1'b1;
    #1;
    checks++;
    if (s_obs !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_async_clear: got %h expected %h", s_obs, RESET_VEC);
    end
    repeat (3) tick();
    checks++;
    if (s_obs !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset_held: got %h expected %h", s_obs, RESET_VEC);
    end
    s_rst = 1'b0;
    tick();
    checks++;
    if (s_obs !== FIRST_VEC) begin
      errors++;
      $display("FAIL mid_restart: got %h expected %h", s_obs, FIRST_VEC);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [FRAME_CNT_W-1:0] exp_fc = 10'd1;
    logic [FRAME_CNT_W-1:0] prev_fc = s_frame_cnt;
    logic done = 1'b0;
    for (int c = 0; c < 1024 * 56 + 200 && !done; c++) begin
      tick();
      if (s_frame_start) begin
        exp_fc = exp_fc + 10'd1;
        checks++;
        if (s_frame_cnt !== exp_fc) begin
          errors++;
          if (errors < 10) $display("FAIL frame_cnt: got %0d expected %0d", s_frame_cnt, exp_fc);
        end
        if (exp_fc == 10'd0) begin
          done = 1'b1;
          checks++;
          if (prev_fc !== 10'd1023) begin
            errors++;
            $display("FAIL wrap_prev: got %0d expected 1023", prev_fc);
          end
        end
      end
      prev_fc = s_frame_cnt;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wrap_timeout: got no wrap expected frame_cnt 1023->0");
    end
  endtask

  initial begin
    x_rst = 1'b1;
    x_ce  = 1'b0;
    s_rst = 1'b1;
    s_ce  = 1'b0;
    test_reset();
    test_line_timing();
    test_ce_stall();
    test_frame_timing();
    test_mid_reset();
    test_frame_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
